// File: rtl/instr_encoder_pkg.sv
// Shared RV32I encoding definitions: format select codes and base opcodes,
// used by both the field assembler and the immediate packer.
package instr_encoder_pkg;

    typedef enum logic [2:0] {
        FMT_I    = 3'd0,
        FMT_S    = 3'd1,
        FMT_SB   = 3'd2,
        FMT_UJ   = 3'd3,
        FMT_JALR = 3'd4,
        FMT_U    = 3'd5
    } fmt_e;

    localparam logic [6:0]  OP_I      = 7'b0010011;
    localparam logic [6:0]  OP_S      = 7'b0100011;
    localparam logic [6:0]  OP_SB     = 7'b1100011;
    localparam logic [6:0]  OP_UJ     = 7'b1101111;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;
    localparam logic [6:0]  OP_U      = 7'b0110111;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/instr_encoder_imm_pack.sv
// Scatters the immediate into its format-specific bit positions (all other
// bits zero) and flags immediates that do not fit or are misaligned.
module instr_encoder_imm_pack
    import instr_encoder_pkg::*;
(
    input  logic [2:0]  i_fmt,
    input  logic [31:0] i_imm,
    output logic [31:0] o_pat,
    output logic        o_err
);

    always_comb begin
        o_pat = 32'd0;
        o_err = 1'b0;
        case (i_fmt)
            FMT_I, FMT_JALR: begin
                o_pat = {i_imm[11:0], 20'd0};
                o_err = (i_imm[31:11] != {21{i_imm[11]}});
            end
            FMT_S: begin
                o_pat = {i_imm[11:5], 13'd0, i_imm[4:0], 7'd0};
                o_err = (i_imm[31:11] != {21{i_imm[11]}});
            end
            // Branch and jump offsets are halfword multiples; bit 0 is never encoded.
            FMT_SB: begin
                o_pat = {i_imm[12], i_imm[10:5], 13'd0, i_imm[4:1], i_imm[11], 7'd0};
                o_err = (i_imm[31:12] != {20{i_imm[12]}}) || i_imm[0];
            end
            FMT_UJ: begin
                o_pat = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], 12'd0};
                o_err = (i_imm[31:20] != {12{i_imm[20]}}) || i_imm[0];
            end
            FMT_U: begin
                o_pat = {i_imm[31:12], 12'd0};
                o_err = (i_imm[11:0] != 12'd0);
            end
            default: begin
                o_pat = 32'd0;
                o_err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder with a single ready/valid output register,
// a running byte address for the held word and a saturating error counter.
module instr_encoder
    import instr_encoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  fmt,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    input  logic        clr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err,
    output logic [31:0] out_addr,
    output logic [7:0]  err_cnt
);

    logic [31:0] w_pat;
    logic        w_imm_err;
    logic [31:0] w_fields;
    logic [31:0] w_instr;
    logic        w_load;
    logic        w_out_hs;
    logic        w_unused_f7;

    logic        r_valid;
    logic [31:0] r_instr;
    logic        r_err;
    logic [31:0] r_addr;
    logic [7:0]  r_cnt;

    instr_encoder_imm_pack u_imm_pack (
        .i_fmt (fmt),
        .i_imm (imm),
        .o_pat (w_pat),
        .o_err (w_imm_err)
    );

    // R-type is not supported, so funct7 never reaches the encoding.
    assign w_unused_f7 = ^funct7;

    always_comb begin
        w_fields = NOP_INSTR;
        case (fmt)
            FMT_I:    w_fields = {12'd0, rs1, funct3, rd, OP_I};
            FMT_JALR: w_fields = {12'd0, rs1, 3'b000, rd, OP_JALR};
            FMT_S:    w_fields = {7'd0, rs2, rs1, funct3, 5'd0, OP_S};
            FMT_SB:   w_fields = {7'd0, rs2, rs1, funct3, 5'd0, OP_SB};
            FMT_UJ:   w_fields = {20'd0, rd, OP_UJ};
            FMT_U:    w_fields = {20'd0, rd, OP_U};
            default:  w_fields = NOP_INSTR;
        endcase
    end

    assign w_instr  = w_fields | w_pat;
    assign in_ready = !r_valid || out_ready;
    assign w_load   = in_valid && in_ready;
    assign w_out_hs = r_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_instr <= 32'd0;
            r_err   <= 1'b0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_instr <= w_instr;
            r_err   <= w_imm_err;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // clr wins over a coincident handshake increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= 32'd0;
            r_cnt  <= 8'd0;
        end else if (clr) begin
            r_addr <= 32'd0;
            r_cnt  <= 8'd0;
        end else if (w_out_hs) begin
            r_addr <= r_addr + 32'd4;
            if (r_err && (r_cnt != 8'hFF))
                r_cnt <= r_cnt + 8'd1;
        end
    end

    assign out_valid = r_valid;
    assign out_instr = r_instr;
    assign out_err   = r_err;
    assign out_addr  = r_addr;
    assign err_cnt   = r_cnt;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: table of hand-encoded vectors streamed
// back-to-back, then backpressure, address wrap, counter saturation, clr and reset cases.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  fmt;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        clr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic [31:0] out_addr;
    logic [7:0]  err_cnt;

    typedef struct {
        logic [2:0]  fmt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp_instr;
        logic        exp_err;
    } vec_t;

    vec_t vecs[20];
    int   nvec = 0;
    int   n_pass = 0;
    int   n_tot = 0;
    int   exp_cnt;

    instr_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fmt       (fmt),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .funct7    (funct7),
        .imm       (imm),
        .clr       (clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .out_addr  (out_addr),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic add(input logic [2:0] f, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] im, input logic [31:0] ei, input logic ee);
        vecs[nvec] = '{f, d, s1, s2, f3, f7, im, ei, ee};
        nvec++;
    endtask

    task automatic drive(input vec_t v, input logic vld);
        fmt = v.fmt; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
        funct3 = v.f3; funct7 = v.f7; imm = v.imm; in_valid = vld;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        add(FMT_I,    5'd1,  5'd2, 5'd0, 3'd0, 7'd0,   32'hFFFF_FFFF, 32'hFFF1_0093, 1'b0);
        add(FMT_SB,   5'd0,  5'd1, 5'd2, 3'd0, 7'd0,   32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b0);
        add(FMT_SB,   5'd0,  5'd1, 5'd2, 3'd0, 7'd0,   32'd3,         32'h0020_8163, 1'b1);
        add(FMT_U,    5'd5,  5'd0, 5'd0, 3'd0, 7'd0,   32'h1234_5000, 32'h1234_52B7, 1'b0);
        add(FMT_U,    5'd5,  5'd0, 5'd0, 3'd0, 7'd0,   32'h1234_5001, 32'h1234_52B7, 1'b1);
        add(FMT_S,    5'd0,  5'd2, 5'd3, 3'd2, 7'd0,   32'd8,         32'h0031_2423, 1'b0);
        add(FMT_JALR, 5'd1,  5'd5, 5'd0, 3'd7, 7'd0,   32'd0,         32'h0002_80E7, 1'b0);
        add(FMT_UJ,   5'd1,  5'd0, 5'd0, 3'd0, 7'd0,   32'd8,         32'h0080_00EF, 1'b0);
        add(FMT_UJ,   5'd0,  5'd0, 5'd0, 3'd0, 7'd0,   32'hFFFF_FFFE, 32'hFFFF_F06F, 1'b0);
        add(FMT_UJ,   5'd0,  5'd0, 5'd0, 3'd0, 7'd0,   32'h0010_0000, 32'h8000_006F, 1'b1);
        add(FMT_I,    5'd0,  5'd0, 5'd0, 3'd0, 7'd0,   32'd2047,      32'h7FF0_0013, 1'b0);
        add(FMT_I,    5'd0,  5'd0, 5'd0, 3'd0, 7'd0,   32'd2048,      32'h8000_0013, 1'b1);
        add(FMT_I,    5'd0,  5'd0, 5'd0, 3'd0, 7'd0,   32'hFFFF_F800, 32'h8000_0013, 1'b0);
        add(FMT_SB,   5'd0,  5'd0, 5'd0, 3'd0, 7'd0,   32'd4094,      32'h7E00_0FE3, 1'b0);
        add(FMT_SB,   5'd0,  5'd0, 5'd0, 3'd0, 7'd0,   32'hFFFF_F000, 32'h8000_0063, 1'b0);
        add(FMT_SB,   5'd0,  5'd0, 5'd0, 3'd0, 7'd0,   32'd4096,      32'h8000_0063, 1'b1);
        add(3'd6,     5'd3,  5'd4, 5'd5, 3'd1, 7'd0,   32'd0,         32'h0000_0013, 1'b1);
        add(3'd7,     5'd3,  5'd4, 5'd5, 3'd1, 7'd0,   32'd4,         32'h0000_0013, 1'b1);
        add(FMT_I,    5'd2,  5'd3, 5'd0, 3'd3, 7'h7F,  32'd5,         32'h0051_B113, 1'b0);
        add(FMT_U,    5'd31, 5'd0, 5'd0, 3'd0, 7'd0,   32'hFFFF_F000, 32'hFFFF_FFB7, 1'b0);

        rst = 1'b1; clr = 1'b0; out_ready = 1'b0;
        drive(vecs[0], 1'b0);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_addr",  out_addr, 32'd0);
        chk("rst_err_cnt",   {24'd0, err_cnt}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Table vectors, streamed one per cycle with the sink always ready.
        out_ready = 1'b1;
        exp_cnt = 0;
        for (int i = 0; i < nvec; i++) begin
            @(negedge clk);
            drive(vecs[i], 1'b1);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("vec%0d_instr", i), out_instr, vecs[i].exp_instr);
            chk($sformatf("vec%0d_err", i),   {31'd0, out_err}, {31'd0, vecs[i].exp_err});
            chk($sformatf("vec%0d_addr", i),  out_addr, 32'(4 * i));
            chk($sformatf("vec%0d_cnt", i),   {24'd0, err_cnt}, 32'(exp_cnt));
            if (vecs[i].exp_err) exp_cnt++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("stream_drain_valid", {31'd0, out_valid}, 32'd0);
        chk("stream_err_cnt", {24'd0, err_cnt}, 32'(exp_cnt));

        // Backpressure: word A held for 3 stalled cycles, then B, C back-to-back.
        do_reset();
        out_ready = 1'b1;
        drive(vecs[0], 1'b1);
        @(posedge clk); #1;
        chk("bp_a_instr", out_instr, 32'hFFF1_0093);
        chk("bp_a_addr", out_addr, 32'd0);
        @(negedge clk);
        out_ready = 1'b0;
        drive(vecs[1], 1'b1);
        #1;
        chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_stall%0d_instr", k), out_instr, 32'hFFF1_0093);
            chk($sformatf("bp_stall%0d_addr", k), out_addr, 32'd0);
            chk($sformatf("bp_stall%0d_in_ready", k), {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_b_instr", out_instr, 32'hFE20_8EE3);
        chk("bp_b_addr", out_addr, 32'd4);
        @(negedge clk);
        drive(vecs[3], 1'b1);
        @(posedge clk); #1;
        chk("bp_c_instr", out_instr, 32'h1234_52B7);
        chk("bp_c_addr", out_addr, 32'd8);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("bp_drain_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_drain_addr", out_addr, 32'd12);

        // Address wrap from a preset near the top of the address space.
        @(negedge clk);
        force dut.r_addr = 32'hFFFF_FFF8;
        #1;
        release dut.r_addr;
        #1;
        chk("wrap_preset", out_addr, 32'hFFFF_FFF8);
        @(negedge clk);
        drive(vecs[0], 1'b1);
        @(posedge clk); #1;
        chk("wrap_addr_fff8", out_addr, 32'hFFFF_FFF8);
        @(negedge clk);
        drive(vecs[1], 1'b1);
        @(posedge clk); #1;
        chk("wrap_addr_fffc", out_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("wrap_addr_zero", out_addr, 32'd0);

        // 256 errored words saturate the counter at 255.
        do_reset();
        out_ready = 1'b1;
        drive(vecs[16], 1'b1);
        repeat (256) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("sat_err_cnt", {24'd0, err_cnt}, 32'd255);
        chk("sat_addr", out_addr, 32'd1024);

        // clr while holding a stalled word, then clr against an errored handshake.
        @(negedge clk);
        drive(vecs[0], 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; clr = 1'b1;
        @(posedge clk); #1;
        chk("clr_hold_addr", out_addr, 32'd0);
        chk("clr_hold_cnt", {24'd0, err_cnt}, 32'd0);
        chk("clr_hold_valid", {31'd0, out_valid}, 32'd1);
        chk("clr_hold_instr", out_instr, 32'hFFF1_0093);
        @(negedge clk);
        clr = 1'b0; out_ready = 1'b1;
        drive(vecs[17], 1'b1);
        @(posedge clk); #1;
        chk("clr_pre_addr", out_addr, 32'd4);
        chk("clr_pre_err", {31'd0, out_err}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0; clr = 1'b1;
        @(posedge clk); #1;
        chk("clr_hs_addr", out_addr, 32'd0);
        chk("clr_hs_cnt", {24'd0, err_cnt}, 32'd0);
        chk("clr_hs_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        clr = 1'b0;

        // Asynchronous reset while a stalled errored word is held.
        drive(vecs[17], 1'b1);
        @(posedge clk); #1;
        chk("rs_pre_valid", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rs_async_valid", {31'd0, out_valid}, 32'd0);
        chk("rs_async_instr", out_instr, 32'd0);
        chk("rs_async_err", {31'd0, out_err}, 32'd0);
        chk("rs_async_addr", out_addr, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("rs_release_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rs_release_valid", {31'd0, out_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 in_valid  input  1  field bundle valid.
REQ-004 in_ready  output  1  encoder can accept bundle this cycle.
REQ-005 fmt  input  3  format select: I, S, SB, UJ, JALR, U (enum from package).
REQ-006 rd, rs1, rs2  input  5 each  register fields.
REQ-007 funct3  input  3; funct7  input  7  function fields.
REQ-008 imm  input  32  signed immediate, byte offset for SB/UJ, full 32-bit value for U.
REQ-009 clr  input  1  synchronous clear of out_addr and err_cnt.
REQ-010 out_valid  output  1  encoded word valid.
REQ-011 out_ready  input  1  downstream (instruction-memory loader) accepts word.
REQ-012 out_instr  output  32  encoded RV32I word.
REQ-013 out_err  output  1  immediate of the held word was out of range or misaligned.
REQ-014 out_addr  output  32  byte address of held word.
REQ-015 err_cnt  output  8  saturating count of errored words accepted downstream.

Function
REQ-016 Opcodes SHALL be: I 0010011, S 0100011, SB 1100011, UJ 1101111, JALR 1100111, U 0110111.
REQ-017 I, JALR: {imm[11:0], rs1, funct3, rd, opcode}; JALR SHALL use funct3 000, ignoring the funct3 input.
REQ-018 S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
REQ-019 SB: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
REQ-020 UJ: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
REQ-021 U: {imm[31:12], rd, opcode}.
REQ-022 funct7 SHALL be ignored for all formats here (R-type out of scope).
REQ-023 Range checks: I/JALR/S -2048..2047; SB -4096..4094 and imm[0]=0; UJ -1048576..1048574 and imm[0]=0; U imm[11:0]=0.
REQ-024 Failed check SHALL still emit the truncated encoding, with out_err=1.
REQ-025 Undefined fmt codes SHALL encode 32'h0000_0013 (NOP) with out_err=1.
REQ-026 Single output register; latency exactly 1 cycle from in handshake to out_valid.
REQ-027 in_ready = !out_valid || out_ready (combinational).
REQ-028 Load on in_valid && in_ready; out_valid cleared when out_ready && !in_valid.
REQ-029 Held out_instr/out_err/out_addr SHALL stay stable while out_valid && !out_ready.
REQ-030 out_addr SHALL increment by 4 on each output handshake, wrapping 32'hFFFF_FFFC -> 0.
REQ-031 err_cnt SHALL increment on each output handshake with out_err=1, saturating at 255.
REQ-032 clr SHALL zero out_addr and err_cnt; it SHALL override a simultaneous increment; pipeline contents unaffected.
REQ-033 Simultaneous output handshake and new input load SHALL sustain one word per cycle.

Reset
REQ-034 rst SHALL force out_valid=0, out_instr=0, out_err=0, out_addr=0, err_cnt=0 immediately, regardless of clk.
REQ-035 Reset mid-transfer SHALL drop the held word; in_ready SHALL be 1 after release.

Structure
REQ-036 Package SHALL hold the fmt enum and the opcode constants, shared with the immediate decoder.
REQ-037 Sub-module imm_pack (combinational: fmt, imm -> 32-bit field pattern, range error) SHALL be instantiated once.

Verification
REQ-038 I: fmt=I, rd=1, rs1=2, funct3=0, imm=-1 -> out_instr 32'hFFF10093, out_err=0, one cycle later.
REQ-039 SB: rs1=1, rs2=2, funct3=0, imm=-4 -> 32'hFE208EE3; imm=3 -> out_err=1, err_cnt=1 after accept.
REQ-040 U: rd=5, imm=32'h12345000 -> 32'h123452B7; imm=32'h12345001 -> out_err=1.
REQ-041 Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_instr stable, out_addr unchanged; out_ready=1 -> back-to-back words, out_addr 0,4,8.
REQ-042 Edges: out_addr preset near 32'hFFFF_FFFC wraps to 0; 256 errored words -> err_cnt=255; clr with handshake -> 0; rst mid-stall -> out_valid=0 asynchronously.
